// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port round-robin arbiter and command sequencer in front
// of an SDRAM controller host interface. Each grant becomes a single
// rd_enable/wr_enable handshake; completion is tracked through the
// controller's busy signal and reported with a one-cycle ack per port.
//
// Ports
//   clk, rst                    clock, async active-high reset
//   pN_req/wr/addr/wdata        request side, N = 0,1 (held until pN_ack)
//   pN_ack/err/rdata            one-cycle completion, timeout flag, read data
//   haddr, data_input           latched address / write data to controller
//   rd_enable, wr_enable        command strobes to controller
//   busy, data_output           controller status and read data
module sdram_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] haddr,
  output logic [DATA_W-1:0] data_input,
  output logic              rd_enable,
  output logic              wr_enable,
  input  logic              busy,
  input  logic [DATA_W-1:0] data_output
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e                   state_q, state_d;
  logic                     sel_q, sel_d, last_q, last_d, wr_q, wr_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [1:0]               ack_q, ack_d, aerr_q, aerr_d;
  logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;
  logic                     gnt;

  // Tie goes to the port that did not win last time; a lone request wins.
  assign gnt = (p0_req && p1_req) ? ~last_q : p1_req;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rd_en_d = rd_en_q;
    wr_en_d = wr_en_q;
    ack_d   = '0;
    aerr_d  = '0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          sel_d   = gnt;
          last_d  = gnt;
          wr_d    = gnt ? p1_wr    : p0_wr;
          addr_d  = gnt ? p1_addr  : p0_addr;
          wdata_d = gnt ? p1_wdata : p0_wdata;
          cnt_d   = '0;
          wr_en_d = gnt ? p1_wr    : p0_wr;
          rd_en_d = gnt ? !p1_wr   : !p0_wr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (busy) begin
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          cnt_d   = '0;
          state_d = WAIT;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          // Enable has now been high for TIMEOUT cycles with no response.
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT: begin
        if (!busy) begin
          if (!wr_q) rdata_d[sel_q] = data_output;
          state_d = DONE;
        end
      end
      DONE: begin
        ack_d[sel_q]  = 1'b1;
        aerr_d[sel_q] = err_q;
        err_d         = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      ack_q   <= '0;
      aerr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      ack_q   <= ack_d;
      aerr_q  <= aerr_d;
      rdata_q <= rdata_d;
    end
  end

  assign haddr      = addr_q;
  assign data_input = wdata_q;
  assign rd_enable  = rd_en_q;
  assign wr_enable  = wr_en_q;
  assign p0_ack     = ack_q[0];
  assign p1_ack     = ack_q[1];
  assign p0_err     = aerr_q[0];
  assign p1_err     = aerr_q[1];
  assign p0_rdata   = rdata_q[0];
  assign p1_rdata   = rdata_q[1];

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;

  logic          clk = 1'b0, rst = 1'b1;
  logic          p0_req = 1'b0, p0_wr = 1'b0, p1_req = 1'b0, p1_wr = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_ack, p0_err, p1_ack, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] haddr;
  logic [DW-1:0] data_input;
  logic          rd_enable, wr_enable;
  logic          busy = 1'b0;
  logic [DW-1:0] data_output = '0;

  int errs = 0, checks = 0, cyc = 0;
  int rd_cyc = 0, wr_cyc = 0, a0n = 0, a1n = 0;
  int bcnt = 0;
  logic          tie_low = 1'b0;
  logic [DW-1:0] mdl_rdata = '0;

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .haddr(haddr), .data_input(data_input),
    .rd_enable(rd_enable), .wr_enable(wr_enable),
    .busy(busy), .data_output(data_output)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Controller model: busy rises half a cycle after an enable is seen and
  // stays high for 5 cycles; read data is presented as busy falls.
  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0;
      bcnt = 0;
    end else if (bcnt != 0) begin
      bcnt--;
      if (bcnt == 0) begin
        busy        = 1'b0;
        data_output = mdl_rdata;
      end
    end else if ((rd_enable || wr_enable) && !tie_low) begin
      busy = 1'b1;
      bcnt = 5;
    end
  end

  always @(negedge clk) begin
    if (rd_enable) rd_cyc++;
    if (wr_enable) wr_cyc++;
    if (p0_ack) a0n++;
    if (p1_ack) a1n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output int port, output logic err, output logic [AW-1:0] a, output int at);
    int n = 0;
    port = -1; err = 1'b0; a = '0; at = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p0_ack || p1_ack) && n < 200);
    if (!(p0_ack || p1_ack)) chk("ack_timeout", 32'd0, 32'd1);
    else begin
      port = p1_ack ? 1 : 0;
      err  = p0_err | p1_err;
      a    = haddr;
      at   = cyc;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int port, at, at1, st, s0, s1, s2, n;
    logic err;
    logic [AW-1:0] a;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_haddr", 32'(haddr), 32'h0);
    chk("rst_wdata", 32'(data_input), 32'h0);
    chk("rst_rd_en", 32'(rd_enable), 32'h0);
    chk("rst_wr_en", 32'(wr_enable), 32'h0);
    chk("rst_acks", {p0_ack, p1_ack, p0_err, p1_err}, 32'h0);
    chk("rst_rdata", {p0_rdata, p1_rdata}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // single write on port 0
    s0 = wr_cyc; s1 = a1n; s2 = a0n;
    p0_addr = 24'hfedbed; p0_wdata = 16'd3333; p0_wr = 1'b1; p0_req = 1'b1; st = cyc;
    wait_ack(port, err, a, at);
    p0_req = 1'b0;
    chk("w_port", 32'(port), 32'd0);
    chk("w_err", 32'(err), 32'd0);
    chk("w_haddr", 32'(a), 32'hfedbed);
    chk("w_data", 32'(data_input), 32'd3333);
    chk("w_latency", 32'(at - st), 32'd8);
    @(negedge clk);
    chk("w_ack_1cyc", 32'(p0_ack), 32'd0);
    repeat (3) @(negedge clk);
    chk("w_en_cycles", 32'(wr_cyc - s0), 32'd1);
    chk("w_p0_acks", 32'(a0n - s2), 32'd1);
    chk("w_p1_quiet", 32'(a1n - s1), 32'd0);

    // read on port 1
    s0 = rd_cyc; s1 = wr_cyc;
    mdl_rdata = 16'hbbbb;
    p1_addr = 24'hbedfed; p1_wr = 1'b0; p1_req = 1'b1;
    wait_ack(port, err, a, at);
    p1_req = 1'b0;
    chk("r_port", 32'(port), 32'd1);
    chk("r_haddr", 32'(a), 32'hbedfed);
    chk("r_rdata", 32'(p1_rdata), 32'hbbbb);
    chk("r_p0_rdata", 32'(p0_rdata), 32'h0);
    repeat (3) @(negedge clk);
    chk("r_rd_used", 32'(rd_cyc - s0), 32'd1);
    chk("r_no_wr", 32'(wr_cyc - s1), 32'd0);

    // simultaneous requests from reset: p0, p1, p0, p1
    do_reset();
    s0 = a0n; s1 = a1n;
    mdl_rdata = 16'h1234;
    p0_addr = 24'h000111; p0_wr = 1'b1; p0_wdata = 16'h0011;
    p1_addr = 24'h000222; p1_wr = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(port, err, a, at);
      if (i == 3) begin p0_req = 1'b0; p1_req = 1'b0; end
      chk($sformatf("tie_port%0d", i), 32'(port), 32'(i % 2));
      chk($sformatf("tie_addr%0d", i), 32'(a), (i % 2) ? 32'h000222 : 32'h000111);
    end
    repeat (15) @(negedge clk);
    chk("tie_acks", 32'((a0n - s0) + (a1n - s1)), 32'd4);
    chk("tie_rdata", 32'(p1_rdata), 32'h1234);

    // port 0 only, request held for two transactions
    s0 = a1n; s1 = wr_cyc;
    p0_addr = 24'h000333; p0_wr = 1'b1; p0_req = 1'b1;
    wait_ack(port, err, a, at1);
    chk("hold_port0", 32'(port), 32'd0);
    chk("hold_bubble", 32'(wr_enable), 32'd0);
    @(negedge clk);
    chk("hold_reissue", 32'(wr_enable), 32'd1);
    wait_ack(port, err, a, at);
    p0_req = 1'b0;
    chk("hold_port1", 32'(port), 32'd0);
    chk("hold_spacing", 32'(at - at1), 32'd8);
    repeat (3) @(negedge clk);
    chk("hold_en", 32'(wr_cyc - s1), 32'd2);
    chk("hold_p1_quiet", 32'(a1n - s0), 32'd0);

    // timeout with busy stuck low
    tie_low = 1'b1;
    s0 = rd_cyc;
    p0_addr = 24'h000444; p0_wr = 1'b0; p0_req = 1'b1;
    wait_ack(port, err, a, at);
    p0_req = 1'b0;
    chk("to_port", 32'(port), 32'd0);
    chk("to_err", 32'(p0_err), 32'd1);
    chk("to_rdata", 32'(p0_rdata), 32'h0);
    @(negedge clk);
    chk("to_clear", {p0_ack, p0_err, rd_enable}, 32'h0);
    chk("to_en_cycles", 32'(rd_cyc - s0), 32'd8);
    tie_low = 1'b0;
    repeat (2) @(negedge clk);

    // reset while in WAIT
    p0_addr = 24'h000555; p0_wr = 1'b1; p0_wdata = 16'h0055; p0_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy && !wr_enable && !rd_enable) && n < 20);
    chk("rw_reached_wait", 32'(busy), 32'd1);
    rst = 1'b1; p0_req = 1'b0;
    #1;
    chk("rw_outs", {haddr, wr_enable, rd_enable, p0_ack, p1_ack}, 32'h0);
    chk("rw_rdata", {p0_rdata, p1_rdata}, 32'h0);
    chk("rw_wdata", 32'(data_input), 32'h0);
    s0 = a0n; s1 = a1n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("rw_no_ack", 32'((a0n - s0) + (a1n - s1)), 32'd0);
    mdl_rdata = 16'h5a5a;
    p1_addr = 24'h123456; p1_wr = 1'b0; p1_req = 1'b1;
    wait_ack(port, err, a, at);
    p1_req = 1'b0;
    chk("rw_next_port", 32'(port), 32'd1);
    chk("rw_next_rdata", 32'(p1_rdata), 32'h5a5a);
    chk("rw_next_err", 32'(err), 32'd0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter and command sequencer in front of `sdram_controller`'s host interface. It accepts read/write requests from two independent requesters and grants them round-robin. It issues each granted request as one `rd_enable`/`wr_enable` handshake and tracks the controller's `busy` through completion. Read data is returned to the granted port with a single-cycle acknowledge.

## Interface
Parameters:
- `ADDR_W`, 24, host address width (matches `haddr`)
- `DATA_W`, 16, data width
- `TIMEOUT`, 64, cycles allowed in ISSUE for `busy` to rise before aborting; 1 ≤ TIMEOUT ≤ 255

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `p0_req`  in  1  port 0 request, level; held until `p0_ack`
- `p0_wr`  in  1  1 = write, 0 = read; stable while `p0_req`
- `p0_addr`  in  ADDR_W  address; stable while `p0_req`
- `p0_wdata`  in  DATA_W  write data; stable while `p0_req`
- `p0_ack`  out  1  one-cycle completion pulse
- `p0_err`  out  1  one-cycle pulse coincident with `p0_ack` on timeout
- `p0_rdata`  out  DATA_W  read data, valid in `p0_ack` cycle of a read
- `p1_*`  same seven signals for port 1
- `haddr`  out  ADDR_W  to controller
- `data_input`  out  DATA_W  to controller
- `rd_enable`  out  1  to controller
- `wr_enable`  out  1  to controller
- `busy`  in  1  from controller
- `data_output`  in  DATA_W  from controller

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any `pN_req` is high, select a port and latch `sel`, `wr`, `addr`, `wdata`; go to ISSUE.
  - Arbitration: if one request is high, grant it. If both are high, grant the port not equal to `last`, then `last <= sel`. A single grant also updates `last`.
- ISSUE:
  - `haddr`/`data_input` are driven from the latched values.
  - `wr_enable` = latched wr; `rd_enable` = !latched wr.
  - Timeout counter increments each cycle.
  - `busy` == 1: drop the enable, clear the counter, go to WAIT.
  - Counter reaches TIMEOUT−1 with `busy` still 0: drop the enable, set `err`, go to DONE.
- WAIT: enables are 0. When `busy` == 0, capture `data_output` into the selected port's `rdata` (reads only) and go to DONE.
- DONE: assert `p[sel]_ack` (and `p[sel]_err` if set) for exactly one cycle, clear `err`, go to IDLE.
- The unselected port's ack, err and rdata never change.
- `haddr`/`data_input` hold their latched values outside ISSUE. They are zero only after reset.
- If a requester drops `req` before ack, the arbiter ignores it and completes the transaction anyway.
- A request that is still high in the IDLE cycle after its own ack is treated as a new request.

## Timing
- Reset values:
  - State IDLE; `last` = 1, so port 0 wins the first tie.
  - All outputs 0: `haddr`, `data_input`, both enables, all acks, errs and rdata.
  - Counter and `err` 0.
- Reset is asynchronous. Asserting it mid-transaction drops enables immediately, returns to IDLE, and issues no ack. The controller's in-flight operation is not tracked after reset.
- All outputs are registered; none depends combinationally on inputs.
- Latency, with `req` sampled in IDLE at edge T:
  - Enable is high from T+1.
  - With `busy` first sampled high at edge T+1+a, enable is low from T+2+a.
  - With `busy` sampled low at edge T+2+a+b, `ack` is high for the cycle after edge T+3+a+b.
  - Minimum request-to-ack is 4 cycles (a = 0, b = 0).
- Enable stays high for at least 1 and at most TIMEOUT cycles.
- Throughput: the next grant is decided in the IDLE cycle following DONE. Back-to-back transactions therefore have a 1-cycle bubble.
- Ties are decided in IDLE only; a request arriving during ISSUE/WAIT/DONE waits.

## Test plan
- **Single write on port 0:** addr 24'hfedbed, wdata 16'd3333. Controller model raises `busy` 1 cycle after `wr_enable` for 5 cycles. Expected:
  - `wr_enable` is high exactly until `busy` is sampled.
  - `haddr` = fedbed.
  - `p0_ack` pulses once, `p0_err` = 0, `p1_ack` never pulses.
- **Read on port 1:** addr 24'hbedfed. Model drives `data_output` = 16'hbbbb when dropping `busy`. Expected: `rd_enable` used, `p1_ack` pulses, `p1_rdata` = bbbb, `p0_rdata` unchanged at 0.
- **Simultaneous requests** from reset, both held for 4 transactions. Expected: grants in order p0, p1, p0, p1; each ack corresponds to its own addr.
- **Port 0 only, req held high:** Expected: consecutive grants to p0 with a 1-cycle IDLE between DONE and ISSUE; no p1 activity.
- **Timeout:** `busy` tied low, TIMEOUT = 8. Expected: enable high for exactly 8 cycles, then `p0_ack` and `p0_err` pulse together, return to IDLE.
- **Reset mid-WAIT:** assert `rst` while `busy` is high. Expected: enables, acks and all outputs 0 immediately; no ack after release; the next request issues normally.
